// File: rtl/bcd_pkg.sv
// Shared BCD arithmetic constants and the serial subtractor state encoding.
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam logic [3:0]  BCD_SIX     = 4'd6;
    localparam logic [3:0]  BCD_MAX     = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUB,
        S_FIX,
        S_DONE
    } state_t;

endpackage

// File: rtl/bcd_serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial BCD subtractor.
interface bcd_serial_subtractor_if #(
    parameter int unsigned DIGITS = 14
);

    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   diff;
    logic                  negative;
    logic                  invalid;

    modport master (
        output start, a, b,
        input  busy, done, diff, negative, invalid
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, negative, invalid
    );

endinterface

// File: rtl/bcd_digit_sub.sv
// One BCD digit of subtraction with borrow: d = x - y - bin, corrected by 6 on borrow.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);

    logic [4:0] t;

    always_comb begin
        t = {1'b0, x} - {1'b0, y} - {4'b0000, bin};
        if (t[4]) begin
            d    = t[3:0] - BCD_SIX;
            bout = 1'b1;
        end else begin
            d    = t[3:0];
            bout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial |a - b| in BCD, LSD first; a negative result gets a second
// ten's-complement pass over the result register so diff is always a magnitude.
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 14
) (
    input  logic                          clk,
    input  logic                          rst,
    bcd_serial_subtractor_if.slave        bus
);

    localparam int unsigned W  = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t          state;
    state_t          state_next;

    logic [W-1:0]    a_sr;
    logic [W-1:0]    b_sr;
    logic [W-1:0]    res;
    logic [W-1:0]    res_shifted;
    logic [CW-1:0]   cnt;
    logic            borrow;
    logic            inv_lat;
    logic            inv_in;
    logic            last;

    logic [W-1:0]    diff_q;
    logic            negative_q;
    logic            invalid_q;

    logic [3:0]      x;
    logic [3:0]      y;
    logic [3:0]      d;
    logic            bout;

    // FIX reuses the same digit unit: 0 - result digit yields the ten's complement.
    always_comb begin
        x = a_sr[3:0];
        y = b_sr[3:0];
        if (state == S_FIX) begin
            x = '0;
            y = res[3:0];
        end
    end

    bcd_digit_sub u_digit (
        .x    (x),
        .y    (y),
        .bin  (borrow),
        .d    (d),
        .bout (bout)
    );

    assign last        = (cnt == CW'(DIGITS - 1));
    assign res_shifted = {d, res[W-1:BCD_DIGIT_W]};

    always_comb begin
        inv_in = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bus.a[BCD_DIGIT_W*i +: BCD_DIGIT_W] > BCD_MAX ||
                bus.b[BCD_DIGIT_W*i +: BCD_DIGIT_W] > BCD_MAX) begin
                inv_in = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (bus.start) state_next = S_SUB;
            S_SUB: begin
                if (last) begin
                    state_next = (inv_lat || !bout) ? S_DONE : S_FIX;
                end
            end
            S_FIX:  if (last) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res        <= '0;
            cnt        <= '0;
            borrow     <= 1'b0;
            inv_lat    <= 1'b0;
            diff_q     <= '0;
            negative_q <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_sr    <= bus.a;
                        b_sr    <= bus.b;
                        inv_lat <= inv_in;
                        borrow  <= 1'b0;
                        cnt     <= '0;
                    end
                end
                S_SUB: begin
                    a_sr   <= a_sr >> BCD_DIGIT_W;
                    b_sr   <= b_sr >> BCD_DIGIT_W;
                    res    <= res_shifted;
                    borrow <= bout;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        cnt    <= '0;
                        borrow <= 1'b0;
                        if (inv_lat) begin
                            diff_q     <= '0;
                            negative_q <= 1'b0;
                            invalid_q  <= 1'b1;
                        end else if (!bout) begin
                            diff_q     <= res_shifted;
                            negative_q <= 1'b0;
                            invalid_q  <= 1'b0;
                        end
                    end
                end
                S_FIX: begin
                    res    <= res_shifted;
                    borrow <= bout;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        cnt        <= '0;
                        borrow     <= 1'b0;
                        diff_q     <= res_shifted;
                        negative_q <= 1'b1;
                        invalid_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state == S_SUB) || (state == S_FIX);
    assign bus.done     = (state == S_DONE);
    assign bus.diff     = diff_q;
    assign bus.negative = negative_q;
    assign bus.invalid  = invalid_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Randomized and directed checks of the serial BCD subtractor against an integer model.
module tb_bcd_serial_subtractor;

    localparam int unsigned DIGITS = 14;
    localparam int unsigned W      = 4 * DIGITS;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] prev_diff;
    logic         prev_neg;
    logic         prev_inv;

    always #5 clk = ~clk;

    bcd_serial_subtractor_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit has_bad(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic longint unsigned to_int(input logic [W-1:0] v);
        longint unsigned r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input longint unsigned n);
        logic [W-1:0] v = '0;
        for (int i = 0; i < DIGITS; i++) begin
            v[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return v;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v = '0;
        int nd = $urandom_range(1, DIGITS);
        for (int i = 0; i < nd; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int ext, input string tag);
        logic [W-1:0]    ed;
        logic            en;
        logic            ei;
        int              lat;
        int              cyc;
        int              extra_dones;
        longint unsigned ai;
        longint unsigned bi;

        ei  = has_bad(a) || has_bad(b);
        ai  = to_int(a);
        bi  = to_int(b);
        en  = 1'b0;
        lat = DIGITS + 1;
        if (ei) begin
            ed = '0;
        end else if (ai < bi) begin
            ed  = to_bcd(bi - ai);
            en  = 1'b1;
            lat = 2 * DIGITS + 1;
        end else begin
            ed = to_bcd(ai - bi);
        end

        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        check({tag, "_hold_diff"}, 64'(bus.diff), 64'(prev_diff));
        check({tag, "_hold_neg"}, 64'(bus.negative), 64'(prev_neg));
        check({tag, "_hold_inv"}, 64'(bus.invalid), 64'(prev_inv));

        while (!bus.done && cyc < 4 * DIGITS) begin
            if (cyc == ext) begin
                bus.start = 1'b1;
                bus.a     = rand_bcd();
                bus.b     = rand_bcd();
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;

        if (!bus.done) begin
            check({tag, "_timeout"}, 64'(cyc), 64'(lat));
        end else begin
            check({tag, "_latency"}, 64'(cyc), 64'(lat));
            check({tag, "_diff"}, 64'(bus.diff), 64'(ed));
            check({tag, "_neg"}, 64'(bus.negative), 64'(en));
            check({tag, "_inv"}, 64'(bus.invalid), 64'(ei));
            check({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
        end
        prev_diff = ed;
        prev_neg  = en;
        prev_inv  = ei;

        @(posedge clk); #1;
        check({tag, "_pulse"}, 64'(bus.done), 64'd0);

        if (ext > 0) begin
            extra_dones = 0;
            repeat (3 * DIGITS) begin
                @(posedge clk); #1;
                if (bus.done) extra_dones++;
            end
            check({tag, "_single_done"}, 64'(extra_dones), 64'd0);
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] nines;
        int           mode;
        int           dones;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_diff", 64'(bus.diff), 64'd0);
        check("rst_neg", 64'(bus.negative), 64'd0);
        check("rst_inv", 64'(bus.invalid), 64'd0);
        rst       = 1'b0;
        prev_diff = '0;
        prev_neg  = 1'b0;
        prev_inv  = 1'b0;

        nines = {DIGITS{4'h9}};
        run_op(W'('h42), W'('h17), 0, "t1");
        run_op(W'('h17), W'('h42), 0, "t2");
        run_op(W'('h1000), W'('h1), 0, "t3a");
        run_op(W'('h0), W'('h1), 0, "t3b");
        run_op(nines, nines, 0, "t4a");
        run_op(W'('h0), nines, 0, "t4b");
        run_op(W'('h1234), W'('hA000), 0, "t5a");
        run_op(W'('h500), W'('h123), 0, "t5b");
        run_op(W'('h42), W'('h17), 3, "t6a");
        run_op(W'('h17), W'('h42), 3, "t6b");

        // Reset in the middle of an operation.
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a     = W'('h42);
        bus.b     = W'('h17);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6r_busy", 64'(bus.busy), 64'd0);
        check("t6r_done", 64'(bus.done), 64'd0);
        check("t6r_diff", 64'(bus.diff), 64'd0);
        check("t6r_neg", 64'(bus.negative), 64'd0);
        check("t6r_inv", 64'(bus.invalid), 64'd0);
        dones = 0;
        repeat (3 * DIGITS) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check("t6r_no_done", 64'(dones), 64'd0);
        prev_diff = '0;
        prev_neg  = 1'b0;
        prev_inv  = 1'b0;

        for (int n = 0; n < 40; n++) begin
            ra   = rand_bcd();
            rb   = rand_bcd();
            mode = $urandom_range(0, 9);
            if (mode < 2) rb = ra;
            else if (mode == 2) rb[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
            else if (mode == 3) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
            run_op(ra, rb, 0, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
